// File: rtl/s3_maxpool_stream_if.sv
// Stream bundle for the stage-3 max-pool: feature beats in, pooled values with flat address out.
interface s3_maxpool_stream_if #(
    parameter int unsigned WIDTH = 35
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [7:0]       out_addr;
    logic             out_last;
    logic             frame_done;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_addr, out_last, frame_done
    );
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_addr, out_last, frame_done
    );
endinterface

// File: rtl/s3_maxpool_stream.sv
// Streaming 2x2 stride-2 max-pool over NUM_MAPS maps of MAP_DIM x MAP_DIM unsigned values.
// Even rows park their horizontal pair maxima in a line buffer; odd rows complete the window.
module s3_maxpool_stream #(
    parameter int unsigned WIDTH    = 35,
    parameter int unsigned MAP_DIM  = 6,
    parameter int unsigned NUM_MAPS = 4
) (
    input logic                clk,
    input logic                rst,
    s3_maxpool_stream_if.slave bus
);
    localparam int unsigned HALF = MAP_DIM / 2;
    localparam int unsigned CW   = (MAP_DIM > 2) ? $clog2(MAP_DIM) : 2;
    localparam int unsigned MW   = (NUM_MAPS > 1) ? $clog2(NUM_MAPS) : 1;

    logic [CW-1:0]    col_q, col_d;
    logic [CW-1:0]    row_q, row_d;
    logic [MW-1:0]    map_q, map_d;
    logic [WIDTH-1:0] hreg_q, hreg_d;
    logic [WIDTH-1:0] lb_q [HALF];
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [7:0]       out_addr_q, out_addr_d;
    logic             out_valid_q, out_valid_d;
    logic             out_last_q, out_last_d;
    logic             fd_q, fd_d;

    logic             accept;
    logic             lb_wr;
    logic [CW-2:0]    lb_idx;
    logic [WIDTH-1:0] hmax;
    logic [WIDTH-1:0] pooled;
    logic             col_end, row_end, map_end;

    assign bus.in_ready   = !(out_valid_q && !bus.out_ready);
    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_data_q;
    assign bus.out_addr   = out_addr_q;
    assign bus.out_last   = out_last_q;
    assign bus.frame_done = fd_q;

    assign accept  = bus.in_valid && bus.in_ready;
    assign lb_idx  = col_q[CW-1:1];
    assign col_end = (col_q == CW'(MAP_DIM - 1));
    assign row_end = (row_q == CW'(MAP_DIM - 1));
    assign map_end = (map_q == MW'(NUM_MAPS - 1));
    assign hmax    = (bus.in_data > hreg_q) ? bus.in_data : hreg_q;
    assign pooled  = (lb_q[lb_idx] > hmax) ? lb_q[lb_idx] : hmax;

    always_comb begin
        col_d       = col_q;
        row_d       = row_q;
        map_d       = map_q;
        hreg_d      = hreg_q;
        lb_wr       = 1'b0;
        out_data_d  = out_data_q;
        out_addr_d  = out_addr_q;
        out_last_d  = out_last_q;
        out_valid_d = out_valid_q;
        fd_d        = out_valid_q && bus.out_ready && out_last_q;

        // Consumption clears first so a same-cycle window completion overrides it.
        if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end

        if (accept) begin
            if (!col_q[0]) begin
                hreg_d = bus.in_data;
            end else if (!row_q[0]) begin
                lb_wr = 1'b1;
            end else begin
                out_data_d  = pooled;
                out_addr_d  = 8'(map_q) * 8'(HALF * HALF) + 8'(row_q >> 1) * 8'(HALF) + 8'(lb_idx);
                out_last_d  = map_end && row_end && col_end;
                out_valid_d = 1'b1;
            end

            if (col_end) begin
                col_d = '0;
                if (row_end) begin
                    row_d = '0;
                    map_d = map_end ? '0 : map_q + 1'b1;
                end else begin
                    row_d = row_q + 1'b1;
                end
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q       <= '0;
            row_q       <= '0;
            map_q       <= '0;
            hreg_q      <= '0;
            out_data_q  <= '0;
            out_addr_q  <= '0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
            fd_q        <= 1'b0;
            for (int unsigned i = 0; i < HALF; i++) begin
                lb_q[i] <= '0;
            end
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            map_q       <= map_d;
            hreg_q      <= hreg_d;
            out_data_q  <= out_data_d;
            out_addr_q  <= out_addr_d;
            out_last_q  <= out_last_d;
            out_valid_q <= out_valid_d;
            fd_q        <= fd_d;
            if (lb_wr) begin
                lb_q[lb_idx] <= hmax;
            end
        end
    end
endmodule

// File: tb/tb_s3_maxpool_stream.sv
// Scoreboard bench for s3_maxpool_stream: window maxima computed from whole frames, checked by a monitor.
module tb_s3_maxpool_stream;
    localparam int unsigned W  = 35;
    localparam int unsigned D  = 6;
    localparam int unsigned NM = 4;
    localparam int unsigned H  = D / 2;
    localparam int unsigned FB = NM * D * D;

    typedef struct {
        logic [W-1:0] data;
        logic [7:0]   addr;
        logic         last;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    s3_maxpool_stream_if #(.WIDTH(W)) bus ();

    s3_maxpool_stream #(
        .WIDTH   (W),
        .MAP_DIM (D),
        .NUM_MAPS(NM)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    exp_t         exp_q[$];
    logic [W-1:0] frame [FB];
    int           total    = 0;
    int           bad      = 0;
    int           rdy_mode = 0;
    int           fd_seen  = 0;
    int           fd_want  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic finish_test();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    endtask

    task automatic check_reset();
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_data", 64'(bus.out_data), 64'd0);
        check("rst_out_addr", 64'(bus.out_addr), 64'd0);
        check("rst_out_last", 64'(bus.out_last), 64'd0);
        check("rst_frame_done", 64'(bus.frame_done), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    endtask

    // Reference: every window whose bottom-right pixel lies within the first 'beats' beats.
    task automatic push_expect(input int unsigned beats);
        exp_t e;
        for (int unsigned m = 0; m < NM; m++) begin
            for (int unsigned pr = 0; pr < H; pr++) begin
                for (int unsigned pc = 0; pc < H; pc++) begin
                    int unsigned  base;
                    logic [W-1:0] mx;
                    base = m * D * D + 2 * pr * D + 2 * pc;
                    if (base + D + 1 < beats) begin
                        mx = frame[base];
                        if (frame[base + 1] > mx)     mx = frame[base + 1];
                        if (frame[base + D] > mx)     mx = frame[base + D];
                        if (frame[base + D + 1] > mx) mx = frame[base + D + 1];
                        e.data = mx;
                        e.addr = 8'(m * H * H + pr * H + pc);
                        e.last = (m == NM - 1) && (pr == H - 1) && (pc == H - 1);
                        if (e.last) fd_want++;
                        exp_q.push_back(e);
                    end
                end
            end
        end
    endtask

    task automatic send_beat(input logic [W-1:0] v, input int unsigned gap_pct);
        int budget;
        while ($urandom_range(99) < gap_pct) begin
            bus.in_valid = 1'b0;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b1;
        bus.in_data  = v;
        budget = 0;
        forever begin
            @(negedge clk);
            if (bus.in_ready) break;
            budget++;
            if (budget > 2000) begin
                check("in_ready_timeout", 64'(bus.in_ready), 64'd1);
                finish_test();
            end
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic send_frame(input int unsigned beats, input int unsigned gap_pct);
        push_expect(beats);
        for (int unsigned i = 0; i < beats; i++) begin
            send_beat(frame[i], gap_pct);
        end
    endtask

    task automatic wait_drain();
        int budget;
        budget = 0;
        while (exp_q.size() != 0 || bus.out_valid) begin
            @(negedge clk);
            budget++;
            if (budget > 2000) begin
                check("drain_timeout", 64'(exp_q.size()), 64'd0);
                finish_test();
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic fill_ramp();
        for (int unsigned i = 0; i < FB; i++) frame[i] = W'(i);
    endtask

    // Consumer ready: 0 = always ready, 1 = random, 2 = stalled.
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = 1'($urandom_range(0, 1));
                default: bus.out_ready = 1'b0;
            endcase
        end
    end

    // Monitor: pops the scoreboard on every output handshake and checks hold/frame_done behaviour.
    initial begin
        logic         fd_exp;
        logic         held;
        logic [W-1:0] hd;
        logic [7:0]   ha;
        logic         hl;
        int           since;
        exp_t         e;
        fd_exp = 1'b0;
        held   = 1'b0;
        hd     = '0;
        ha     = '0;
        hl     = 1'b0;
        since  = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                fd_exp = 1'b0;
                held   = 1'b0;
                since  = 0;
            end else begin
                if (fd_exp || bus.frame_done) begin
                    check("frame_done", 64'(bus.frame_done), 64'(fd_exp));
                    if (bus.frame_done === 1'b1) begin
                        fd_seen++;
                        check("outs_per_frame", 64'(since), 64'(H * H * NM));
                        since = 0;
                    end
                end
                if (held) begin
                    check("hold_valid", 64'(bus.out_valid), 64'd1);
                    check("hold_data", 64'(bus.out_data), 64'(hd));
                    check("hold_addr", 64'(bus.out_addr), 64'(ha));
                    check("hold_last", 64'(bus.out_last), 64'(hl));
                end
                if (bus.out_valid && bus.out_ready) begin
                    since++;
                    if (exp_q.size() == 0) begin
                        check("unexpected_output_addr", 64'(bus.out_addr), 64'hFFFF);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_addr", 64'(bus.out_addr), 64'(e.addr));
                        check("out_data", 64'(bus.out_data), 64'(e.data));
                        check("out_last", 64'(bus.out_last), 64'(e.last));
                    end
                end
                fd_exp = bus.out_valid && bus.out_ready && bus.out_last;
                held   = bus.out_valid && !bus.out_ready;
                hd     = bus.out_data;
                ha     = bus.out_addr;
                hl     = bus.out_last;
            end
        end
    end

    initial begin
        int budget;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset();

        // Ramp frame, always ready.
        rdy_mode = 0;
        fill_ramp();
        send_frame(FB, 0);

        // Single non-zero pixel in map 2, then a saturated all-equal frame.
        for (int unsigned i = 0; i < FB; i++) frame[i] = '0;
        frame[2 * D * D + D + 1] = W'(5);
        send_frame(FB, 0);
        for (int unsigned i = 0; i < FB; i++) frame[i] = {W{1'b1}};
        send_frame(FB, 0);
        wait_drain();

        // Backpressure on the first output for 10 cycles.
        rdy_mode = 2;
        fill_ramp();
        fork
            send_frame(FB, 0);
            begin
                budget = 0;
                do begin
                    @(negedge clk);
                    budget++;
                end while (!bus.out_valid && budget < 200);
                check("bp_first_valid", 64'(bus.out_valid), 64'd1);
                repeat (10) begin
                    check("bp_valid", 64'(bus.out_valid), 64'd1);
                    check("bp_data", 64'(bus.out_data), 64'd7);
                    check("bp_addr", 64'(bus.out_addr), 64'd0);
                    check("bp_in_ready", 64'(bus.in_ready), 64'd0);
                    @(negedge clk);
                end
                rdy_mode = 0;
            end
        join

        // Input bubbles with random consumer readiness.
        rdy_mode = 1;
        fill_ramp();
        send_frame(FB, 50);
        rdy_mode = 0;

        // Two back-to-back random frames: full-range values, then a tie-heavy small range.
        for (int unsigned i = 0; i < FB; i++) frame[i] = {3'($urandom), 32'($urandom)};
        send_frame(FB, 0);
        for (int unsigned i = 0; i < FB; i++) frame[i] = W'($urandom_range(0, 3));
        send_frame(FB, 0);
        wait_drain();

        // Reset after 50 accepted beats, then a clean ramp frame.
        fill_ramp();
        send_frame(50, 0);
        wait_drain();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset();
        send_frame(FB, 0);
        wait_drain();

        repeat (3) @(posedge clk);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        check("frame_done_count", 64'(fd_seen), 64'(fd_want));
        finish_test();
    end
endmodule

// File: doc/s3_maxpool_stream.md
Name: s3_maxpool_stream

Overview:
- Streaming 2x2, stride-2 max-pool stage directly downstream of the stage-2 convolution/ReLU datapath.
- Consumes the stage-2 feature-map values one per beat: NUM_MAPS maps of MAP_DIM x MAP_DIM 35-bit non-negative results.
- Emits pooled values with their flat output address.
- Valid/ready handshake on both sides; a line buffer holds the partial maxima of even rows.

Parameters:
- WIDTH, 35, data width of input and output values (unsigned, post-ReLU).
- MAP_DIM, 6, rows/cols per input map; must be even.
- NUM_MAPS, 4, number of maps per frame (one per filter).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  input beat valid.
- in_ready  output  1  block accepts beat this cycle.
- in_data  input  WIDTH  feature value. Order within a frame: map-major, then row-major.
- out_valid  output  1  pooled value valid.
- out_ready  input  1  consumer accepts pooled value.
- out_data  output  WIDTH  pooled maximum.
- out_addr  output  8  flat index = map*(MAP_DIM/2)^2 + prow*(MAP_DIM/2) + pcol. Range 0..35 at defaults.
- out_last  output  1  high with the final pooled value of a frame (out_addr = 35 at defaults).
- frame_done  output  1  one-cycle pulse when the out_last beat is accepted.

Behaviour:
- Reset values:
  - out_valid=0, out_data=0, out_addr=0, out_last=0, frame_done=0.
  - Column, row and map counters = 0; horizontal-max register = 0; line buffer entries = 0.
  - in_ready = 1 after reset.
- Accept rule: a beat is accepted when in_valid && in_ready.
- in_ready = !(out_valid && !out_ready). in_ready is combinational and drops only while the output register holds an unaccepted value.
- Per accepted beat at position (r, c) of map m:
  - c even: hreg <= in_data.
  - c odd: h = max(hreg, in_data), unsigned compare. On a tie, the value is kept unchanged.
  - r even, c odd: linebuf[c/2] <= h. No output is produced.
  - r odd, c odd:
    - out_data <= max(linebuf[c/2], h)
    - out_addr <= m*(MAP_DIM/2)^2 + (r/2)*(MAP_DIM/2) + c/2
    - out_valid <= 1
    - out_last <= (m == NUM_MAPS-1 && r == MAP_DIM-1 && c == MAP_DIM-1)
- Latency: out_valid rises in the cycle after the window's last beat (bottom-right pixel) is accepted.
- Output handshake:
  - out_valid && out_ready clears out_valid, unless the same cycle loads a new result; then out_valid stays 1 with the new data.
  - Data, addr and last are held stable while out_valid && !out_ready.
- Counter wrap:
  - c wraps MAP_DIM-1 -> 0 and increments r.
  - r wraps MAP_DIM-1 -> 0 and increments m.
  - m wraps NUM_MAPS-1 -> 0, which starts a new frame. There are no idle cycles required between frames.
- frame_done = 1 for exactly one cycle, the cycle after the out_last beat is accepted (registered). It is 0 otherwise.
- Counters advance only on accepted beats. Beats presented while in_valid=0 or in_ready=0 have no effect.
- Reset mid-frame: all counters and output state return to reset values on the next edge. A partial frame is discarded and the next accepted beat is (m=0, r=0, c=0).
- Widths:
  - out_data is exactly WIDTH bits; there is no arithmetic growth, since only compare/select is performed.
  - out_addr is zero-extended to 8 bits.

Test Plan:
- Ramp: reset, then stream one frame with in_data = beat index 0..143, out_ready held 1 -> 36 outputs.
  - First output: out_addr=0, out_data=7.
  - Addr 1: data=9. Addr 8: data=35. Addr 35: data=143.
  - out_last only on addr 35; frame_done pulses once.
- Ties and zeros: a map of all zeros except pixel (1,1)=5 in map 2 -> out_addr 18 data 5; all other outputs 0.
  - All-equal map of value 0x7FFFFFFFF gives all outputs 0x7FFFFFFFF.
- Backpressure: out_ready=0 from the first output for 10 cycles.
  - out_valid stays 1; out_data=7 and out_addr=0 are stable.
  - in_ready=0 for those cycles and no counter advances.
  - After release, the output sequence matches the ramp case exactly.
- Bubbles: random in_valid gaps (50% duty) with random out_ready -> output sequence identical to the ramp case; no duplicated or dropped addresses.
- Back-to-back frames: two frames without gaps -> the second frame starts at out_addr=0; frame_done pulses twice, 36 outputs apart.
- Reset mid-frame: assert rst after 50 accepted beats, then send a full ramp frame -> outputs identical to the ramp case; no stale linebuf values appear.
